uart_tx_fc: RTL and testbench

Byte-oriented UART transmitter with RTS/CTS flow control and a small input FIFO. It is the transmit end of our UART link and drives the serial line and RTS of the matching receiver. It accepts bytes over a valid/ready interface and serialises each one as 1 start bit, 8 data bits LSB-first and 1 stop bit. Each frame is then followed by an idle guard period. A frame is committed only if the receiver answers with CTS during the start bit; otherwise the byte is retried.

---
 rtl/uart_tx_fc_if.sv | 19 +
 rtl/uart_tx_fc.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fc.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fc_if.sv
// Byte write channel into the UART transmitter.
// The producer holds data_in/data_valid until it sees data_ready.
interface uart_tx_fc_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_tx_fc.sv
// UART transmitter, 8N1, with RTS/CTS handshake and input FIFO.
// A frame commits only if CTS answers during the start bit.
module uart_tx_fc #(
  parameter int CLKS_PER_BIT = 13,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_fc_if.slave  s,
  output logic         tx,
  output logic         rts,
  input  logic         cts,
  output logic         busy,
  output logic         abort_err
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_bit_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;

  logic       w_push;
  logic       w_pop;
  logic       w_bit_end;
  logic [7:0] w_head;

  assign w_bit_end    = (r_bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign s.data_ready = (r_count != CNTW'(FIFO_DEPTH));
  assign w_push       = s.data_valid && s.data_ready;
  assign w_pop        = (r_state == STOP) && w_bit_end;
  assign w_head       = r_mem[r_rd_ptr];

  // FIFO storage; the head entry is never written while a frame uses it
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s.data_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame sequencer with registered line outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      tx        <= 1'b1;
      rts       <= 1'b1;
      busy      <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      abort_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_count != '0 && cts) begin
            r_state   <= START;
            r_bit_cnt <= '0;
            tx        <= 1'b0;
            rts       <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (!cts) begin
              r_state <= DATA;
              r_idx   <= '0;
              tx      <= w_head[0];
            end else begin
              r_state   <= IDLE;
              tx        <= 1'b1;
              rts       <= 1'b1;
              busy      <= 1'b0;
              abort_err <= 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
              tx      <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
              tx    <= w_head[r_idx + 3'd1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state   <= GAP;
            r_bit_cnt <= '0;
            rts       <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        GAP: begin
          if (w_bit_end) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            busy      <= 1'b0;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          tx      <= 1'b1;
          rts     <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fc.sv
// Bench for uart_tx_fc: acts as producer and as the remote receiver.
// Line waveforms are rebuilt from the byte values and bit timing.
module tb_uart_tx_fc;

  localparam int N  = 13;
  localparam int D  = 4;
  localparam int FL = 10 * N;

  typedef logic [159:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cts = 1'b1;
  logic tx, rts, busy, abort_err;

  uart_tx_fc_if bus ();

  uart_tx_fc #(
    .CLKS_PER_BIT (N),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (bus),
    .tx        (tx),
    .rts       (rts),
    .cts       (cts),
    .busy      (busy),
    .abort_err (abort_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  vec_t pp_count, pp_rd, pp_wr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    exp_q.push_back(b);
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    while (bus.data_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk("push_accept", vec_t'(bus.data_ready), vec_t'(1'b1));
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (tx !== 1'b0 && n < 4000) begin
      tick();
      n++;
    end
    chk("start_seen", vec_t'(tx), vec_t'(1'b0));
  endtask

  // Receive one committed frame; optionally push a byte on the pop edge
  task automatic rx_frame(input bit do_pp, input logic [7:0] pp_b);
    logic [FL-1:0] otx, orts, etx;
    logic [7:0] want, got;
    int k;
    wait_start();
    cts = 1'b0;
    chk("queue_nonempty", vec_t'(exp_q.size() != 0), vec_t'(1'b1));
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    for (int t = 0; t < FL; t++) begin
      otx[t]  = tx;
      orts[t] = rts;
      k = t / N;
      etx[t] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : want[k-1];
      if (do_pp && t == FL - 1) begin
        exp_q.push_back(pp_b);
        bus.data_in    = pp_b;
        bus.data_valid = 1'b1;
      end
      tick();
    end
    if (do_pp) begin
      bus.data_valid = 1'b0;
      pp_count = vec_t'(dut.r_count);
      pp_rd    = vec_t'(dut.r_rd_ptr);
      pp_wr    = vec_t'(dut.r_wr_ptr);
    end
    for (int i = 0; i < 8; i++) got[i] = otx[(i + 1) * N + N / 2];
    chk("tx_wave", vec_t'(otx), vec_t'(etx));
    chk("rts_low_frame", vec_t'(orts), vec_t'(0));
    chk("rx_byte", vec_t'(got), vec_t'(want));
    chk("gap_line", vec_t'({tx, rts}), vec_t'(2'b11));
    cts = 1'b1;
    for (int t = FL; t < 11 * N - 1; t++) tick();
    chk("gap_busy", vec_t'(busy), vec_t'(1'b1));
    tick();
    chk("idle_busy", vec_t'(busy), vec_t'(1'b0));
  endtask

  initial begin
    logic [7:0] b;
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_line", vec_t'({tx, rts}), vec_t'(2'b11));
    chk("rst_busy", vec_t'({busy, abort_err}), vec_t'(2'b00));
    rst_n = 1'b1;
    tick();
    chk("rst_ready", vec_t'(bus.data_ready), vec_t'(1'b1));

    // single byte 0xA5 with start latency
    push(8'hA5);
    chk("lat_idle", vec_t'(tx), vec_t'(1'b1));
    tick();
    chk("lat_start", vec_t'({tx, rts}), vec_t'(2'b00));
    rx_frame(1'b0, 8'h00);
    chk("a5_count", vec_t'(dut.r_count), vec_t'(0));

    // fill FIFO while receiver holds off, fifth byte stalls
    cts = 1'b0;
    for (int i = 0; i < D; i++) push(8'($urandom));
    chk("full_ready", vec_t'(bus.data_ready), vec_t'(1'b0));
    chk("held_idle", vec_t'({tx, busy}), vec_t'(2'b10));
    b = 8'($urandom);
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    repeat (5) tick();
    chk("stall_ready", vec_t'(bus.data_ready), vec_t'(1'b0));
    fork
      push(b);
      begin
        cts = 1'b1;
        repeat (D + 1) rx_frame(1'b0, 8'h00);
      end
    join
    chk("burst_empty", vec_t'(dut.r_count), vec_t'(0));

    // missing CTS during start bit aborts and retries
    push(8'h3C);
    wait_start();
    for (int t = 0; t < N - 1; t++) tick();
    chk("abort_pre", vec_t'({tx, abort_err}), vec_t'(2'b00));
    tick();
    chk("abort_pulse", vec_t'(abort_err), vec_t'(1'b1));
    chk("abort_line", vec_t'({tx, rts, busy}), vec_t'(3'b110));
    chk("abort_count", vec_t'(dut.r_count), vec_t'(1));
    tick();
    chk("abort_once", vec_t'({abort_err, tx}), vec_t'(2'b00));
    rx_frame(1'b0, 8'h00);
    chk("retry_count", vec_t'(dut.r_count), vec_t'(0));

    // receiver busy before push blocks the start
    cts = 1'b0;
    push(8'($urandom));
    repeat (20) tick();
    chk("blocked", vec_t'({tx, rts, busy}), vec_t'(3'b110));
    cts = 1'b1;
    tick();
    chk("unblock", vec_t'({tx, busy}), vec_t'(2'b01));
    rx_frame(1'b0, 8'h00);

    // random producer gaps against the receiver
    fork
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 20)) tick();
        push(8'($urandom));
      end
      repeat (6) rx_frame(1'b0, 8'h00);
    join

    // reset in the middle of a 0xFF frame with two more queued
    cts = 1'b0;
    push(8'hFF);
    push(8'($urandom));
    push(8'($urandom));
    cts = 1'b1;
    wait_start();
    cts = 1'b0;
    for (int t = 0; t < 4 * N + N / 2; t++) tick();
    chk("mid_data", vec_t'({tx, rts}), vec_t'(2'b10));
    rst_n = 1'b0;
    tick();
    chk("mrst_line", vec_t'({tx, rts, busy}), vec_t'(3'b110));
    chk("mrst_count", vec_t'(dut.r_count), vec_t'(0));
    chk("mrst_ready", vec_t'(bus.data_ready), vec_t'(1'b1));
    rst_n = 1'b1;
    cts = 1'b1;
    exp_q.delete();
    tick();

    // simultaneous push and pop at count 2 with rd_ptr wrapping from 3
    cts = 1'b0;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    cts = 1'b1;
    repeat (3) rx_frame(1'b0, 8'h00);
    chk("ptr_rd3", vec_t'(dut.r_rd_ptr), vec_t'(3));
    cts = 1'b0;
    push(8'($urandom));
    push(8'($urandom));
    chk("pp_pre", vec_t'(dut.r_count), vec_t'(2));
    cts = 1'b1;
    rx_frame(1'b1, 8'($urandom));
    chk("pp_count", pp_count, vec_t'(2));
    chk("pp_rd_wrap", pp_rd, vec_t'(0));
    chk("pp_wr", pp_wr, vec_t'(2));
    repeat (2) rx_frame(1'b0, 8'h00);
    chk("end_count", vec_t'(dut.r_count), vec_t'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
